// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate sensor: FSM state encodings and
// default timing constants.
package parking_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

    localparam logic [2:0] ST_IDLE       = 3'b000;
    localparam logic [2:0] ST_IN_A       = 3'b001;
    localparam logic [2:0] ST_IN_AB      = 3'b010;
    localparam logic [2:0] ST_IN_B       = 3'b011;
    localparam logic [2:0] ST_OUT_B      = 3'b100;
    localparam logic [2:0] ST_OUT_BA     = 3'b101;
    localparam logic [2:0] ST_OUT_A      = 3'b110;
    localparam logic [2:0] ST_WAIT_CLEAR = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_IN_A       = ST_IN_A,
        S_IN_AB      = ST_IN_AB,
        S_IN_B       = ST_IN_B,
        S_OUT_B      = ST_OUT_B,
        S_OUT_BA     = ST_OUT_BA,
        S_OUT_A      = ST_OUT_A,
        S_WAIT_CLEAR = ST_WAIT_CLEAR
    } state_e;

endpackage

// File: rtl/beam_debounce.sv
// One beam channel: 2-flop synchroniser followed by a stability counter that
// only lets the level change after DEBOUNCE_CYCLES consecutive agreeing samples.
module beam_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The FSM consumes the next-state view so it moves on the same edge the
    // debounced flop updates, giving 2 + DEBOUNCE_CYCLES edges of latency.
    assign level_o = level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/parking_gate_sensor.sv
// Two-beam lane sensor front end: debounces beams A/B and decodes direction.
// Barrier control (full/admit/gate_open) is built only when PARKING_GATE_CTRL_EN is defined.
module parking_gate_sensor
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_a,
    input  logic sensor_b,
    input  logic full,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic gate_open,
    output logic seq_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0] raw_beam;
    logic [1:0] beam;
    logic       a, b;

    assign raw_beam = {sensor_a, sensor_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_beam
            beam_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .raw_i  (raw_beam[gi]),
                .level_o(beam[gi])
            );
        end
    endgenerate

    assign a = beam[1];
    assign b = beam[0];

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          entry_q, entry_d;
    logic          exit_q, exit_d;
    logic          err_q, err_d;
    logic          active;
    logic          timeout_hit;

    assign active      = (state_q != S_IDLE) && (state_q != S_WAIT_CLEAR);
    assign timeout_hit = active && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: case ({a, b})
                2'b10:   state_d = S_IN_A;
                2'b01:   state_d = S_OUT_B;
                2'b11:   begin state_d = S_WAIT_CLEAR; err_d = 1'b1; end
                default: ;
            endcase
            S_IN_A: case ({a, b})
                2'b11:   state_d = S_IN_AB;
                2'b00:   state_d = S_IDLE;
                2'b01:   begin state_d = S_WAIT_CLEAR; err_d = 1'b1; end
                default: ;
            endcase
            S_IN_AB: case ({a, b})
                2'b01:   state_d = S_IN_B;
                2'b10:   state_d = S_IN_A;
                2'b00:   begin state_d = S_WAIT_CLEAR; err_d = 1'b1; end
                default: ;
            endcase
            S_IN_B: case ({a, b})
                2'b00:   begin state_d = S_IDLE; entry_d = 1'b1; end
                2'b11:   state_d = S_IN_AB;
                2'b10:   begin state_d = S_WAIT_CLEAR; err_d = 1'b1; end
                default: ;
            endcase
            S_OUT_B: case ({a, b})
                2'b11:   state_d = S_OUT_BA;
                2'b00:   state_d = S_IDLE;
                2'b10:   begin state_d = S_WAIT_CLEAR; err_d = 1'b1; end
                default: ;
            endcase
            S_OUT_BA: case ({a, b})
                2'b10:   state_d = S_OUT_A;
                2'b01:   state_d = S_OUT_B;
                2'b00:   begin state_d = S_WAIT_CLEAR; err_d = 1'b1; end
                default: ;
            endcase
            S_OUT_A: case ({a, b})
                2'b00:   begin state_d = S_IDLE; exit_d = 1'b1; end
                2'b11:   state_d = S_OUT_BA;
                2'b01:   begin state_d = S_WAIT_CLEAR; err_d = 1'b1; end
                default: ;
            endcase
            S_WAIT_CLEAR: begin
                if (!a && !b) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A real transition this cycle takes priority over the timeout.
        if (timeout_hit && (state_d == state_q)) begin
            state_d = S_WAIT_CLEAR;
            err_d   = 1'b1;
        end

        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (active) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    assign entry_pulse = entry_q;
    assign exit_pulse  = exit_q;
    assign seq_error   = err_q;

`ifdef PARKING_GATE_CTRL_EN
    logic admit_q, admit_d;
    logic gate_q, gate_d;

    always_comb begin
        admit_d = admit_q;
        if ((state_q == S_IDLE) && (state_d == S_IN_A)) admit_d = ~full;
        gate_d = 1'b0;
        case (state_d)
            S_IN_A, S_IN_AB, S_IN_B:    gate_d = admit_d;
            S_OUT_B, S_OUT_BA, S_OUT_A: gate_d = 1'b1;
            default:                    gate_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            admit_q <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            admit_q <= admit_d;
            gate_q  <= gate_d;
        end
    end

    assign gate_open = gate_q;
`else
    logic unused_full;
    assign unused_full = full;
    assign gate_open   = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_sensor.sv
// Directed bench for parking_gate_sensor: entry, exit, full lot, glitch,
// back-out, error, timeout and mid-sequence reset scenarios.
module tb_parking_gate_sensor;
    import parking_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 50;
`ifdef PARKING_GATE_CTRL_EN
    localparam int GATE_EN = 1;
`else
    localparam int GATE_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic full = 1'b0;
    logic entry_pulse, exit_pulse, gate_open, seq_error;

    parking_gate_sensor #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_a   (sensor_a),
        .sensor_b   (sensor_b),
        .full       (full),
        .entry_pulse(entry_pulse),
        .exit_pulse (exit_pulse),
        .gate_open  (gate_open),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int n_entry = 0, n_exit = 0, n_err = 0, n_gate = 0, n_busy = 0, n_multi = 0;
    int entry_cyc = 0, exit_cyc = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (entry_pulse) begin n_entry <= n_entry + 1; entry_cyc <= cyc; end
            if (exit_pulse)  begin n_exit  <= n_exit + 1;  exit_cyc  <= cyc; end
            if (seq_error)   begin n_err   <= n_err + 1;   err_cyc   <= cyc; end
            if (gate_open)   n_gate <= n_gate + 1;
            if (dut.state_q != S_IDLE) n_busy <= n_busy + 1;
            if (32'(entry_pulse) + 32'(exit_pulse) + 32'(seq_error) > 1) n_multi <= n_multi + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int mark = 0;
    int b_entry, b_exit, b_err, b_gate, b_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic phase(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        mark = cyc;
        $display("drive a=%0b b=%0b for %0d cycles at cycle %0d", a, b, n, cyc);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_entry = n_entry;
        b_exit  = n_exit;
        b_err   = n_err;
        b_gate  = n_gate;
        b_busy  = n_busy;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_entry", 32'(entry_pulse), 0);
        check("rst_exit",  32'(exit_pulse), 0);
        check("rst_err",   32'(seq_error), 0);
        check("rst_gate",  32'(gate_open), 0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean entry
        snap();
        phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10); phase(0, 0, 10);
        check("entry_count",   32'(n_entry - b_entry), 1);
        check("entry_latency", 32'(entry_cyc - mark), 6);
        check("entry_no_exit", 32'(n_exit - b_exit), 0);
        check("entry_no_err",  32'(n_err - b_err), 0);
        check("entry_gate",    32'(n_gate - b_gate), 32'(30 * GATE_EN));
        check("entry_idle",    32'(dut.state_q), 32'(ST_IDLE));

        // Clean exit
        snap();
        phase(0, 1, 10); phase(1, 1, 10); phase(1, 0, 10); phase(0, 0, 10);
        check("exit_count",    32'(n_exit - b_exit), 1);
        check("exit_latency",  32'(exit_cyc - mark), 6);
        check("exit_no_entry", 32'(n_entry - b_entry), 0);
        check("exit_no_err",   32'(n_err - b_err), 0);
        check("exit_gate",     32'(n_gate - b_gate), 32'(30 * GATE_EN));

        // Full lot: car still counted, barrier stays down
        full = 1'b1;
        snap();
        phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10); phase(0, 0, 10);
        full = 1'b0;
        check("full_entry", 32'(n_entry - b_entry), 1);
        check("full_gate",  32'(n_gate - b_gate), 0);
        check("full_err",   32'(n_err - b_err), 0);

        // 3-cycle glitch must not leave IDLE
        snap();
        phase(1, 0, 3); phase(0, 0, 10);
        check("glitch_busy", 32'(n_busy - b_busy), 0);

        // Back-out: A, AB, A, none
        snap();
        phase(1, 0, 10); phase(1, 1, 10); phase(1, 0, 10); phase(0, 0, 10);
        check("backout_entry", 32'(n_entry - b_entry), 0);
        check("backout_exit",  32'(n_exit - b_exit), 0);
        check("backout_err",   32'(n_err - b_err), 0);
        check("backout_gate",  32'(n_gate - b_gate), 32'(30 * GATE_EN));
        check("backout_idle",  32'(dut.state_q), 32'(ST_IDLE));

        // Both beams at once from IDLE
        snap();
        phase(1, 1, 10);
        check("both_err",     32'(n_err - b_err), 1);
        check("both_err_lat", 32'(err_cyc - mark), 6);
        check("both_wait",    32'(dut.state_q), 32'(ST_WAIT_CLEAR));
        phase(0, 0, 10);
        check("both_recover", 32'(dut.state_q), 32'(ST_IDLE));
        check("both_no_more", 32'(n_err - b_err), 1);

        // Timeout holding A
        snap();
        phase(1, 0, 60);
        check("tmo_err",     32'(n_err - b_err), 1);
        check("tmo_err_lat", 32'(err_cyc - mark), 56);
        check("tmo_wait",    32'(dut.state_q), 32'(ST_WAIT_CLEAR));
        check("tmo_gate",    32'(n_gate - b_gate), 32'(50 * GATE_EN));
        check("tmo_entry",   32'(n_entry - b_entry), 0);
        phase(0, 0, 10);
        check("tmo_recover", 32'(dut.state_q), 32'(ST_IDLE));

        // Reset while in IN_AB
        snap();
        phase(1, 0, 10); phase(1, 1, 8);
        check("pre_rst_state", 32'(dut.state_q), 32'(ST_IN_AB));
        check("pre_rst_gate",  32'(gate_open), 32'(GATE_EN));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("mid_rst_gate",  32'(gate_open), 0);
        check("mid_rst_entry", 32'(entry_pulse), 0);
        check("mid_rst_err",   32'(seq_error), 0);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        snap();
        phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10); phase(0, 0, 10);
        check("post_rst_entry", 32'(n_entry - b_entry), 1);
        check("post_rst_err",   32'(n_err - b_err), 0);
        check("post_rst_gate",  32'(n_gate - b_gate), 32'(30 * GATE_EN));

        check("pulse_exclusive", 32'(n_multi), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_sensor.md
# parking_gate_sensor

Upstream front end of the parking occupancy counter. Watches a two-beam lane sensor: beam A is outer (street side) and beam B is inner (lot side). It synchronises and debounces both beams, then decodes vehicle direction with a sequence FSM. It emits the one-cycle `entry_pulse` / `exit_pulse` the counter consumes, and drives the barrier command from the counter's `full` flag.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required before a beam's debounced level changes; minimum 1.
- `TIMEOUT_CYCLES`, 1000: maximum cycles the FSM may stay in any one non-IDLE state before aborting; minimum 1.
- `clk` input 1: single clock; all state is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sensor_a` input 1: raw outer beam, 1 = blocked, asynchronous to `clk`.
- `sensor_b` input 1: raw inner beam, 1 = blocked, asynchronous to `clk`.
- `full` input 1: lot full flag from the occupancy counter.
- `entry_pulse` output 1: one-cycle pulse when a complete inbound sequence finishes.
- `exit_pulse` output 1: one-cycle pulse when a complete outbound sequence finishes.
- `gate_open` output 1: barrier raise command, level.
- `seq_error` output 1: one-cycle pulse when a sequence is aborted.

## Operation
- Per beam: 2-flop synchroniser, then debounce counter. The counter resets whenever the synchronised value equals the debounced value. When it reaches `DEBOUNCE_CYCLES`, the debounced value flips and the counter clears.
- FSM inputs are the debounced levels `a` and `b`. States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLEAR.
- Inbound path: IDLE →(a&!b) IN_A →(a&b) IN_AB →(!a&b) IN_B →(!a&!b) IDLE, with `entry_pulse`.
- Outbound path: IDLE →(!a&b) OUT_B →(a&b) OUT_BA →(a&!b) OUT_A →(!a&!b) IDLE, with `exit_pulse`.
- Back-outs, no pulse and no error:
  - IN_AB →(a&!b) IN_A; IN_A →(!a&!b) IDLE.
  - IN_B →(a&b) IN_AB.
  - Symmetric for the outbound path: OUT_BA →(!a&b) OUT_B; OUT_B →(!a&!b) IDLE; OUT_A →(a&b) OUT_BA.
- Unchanged inputs hold the current state.
- Any other input combination goes to WAIT_CLEAR with `seq_error`. This includes IDLE with a&b, and IN_A or OUT_B seeing the opposite single beam.
- Timeout: a per-state cycle counter reloads on every state change. Reaching `TIMEOUT_CYCLES` in a non-IDLE state goes to WAIT_CLEAR with `seq_error`.
- WAIT_CLEAR →(!a&!b) IDLE, no pulse. WAIT_CLEAR never times out.
- `full` is sampled on the IDLE→IN_A transition into a latch `admit`.
- `gate_open` = 1 in:
  - IN_A, IN_AB and IN_B while `admit` = 1;
  - OUT_B, OUT_BA and OUT_A, unconditionally (exit is always allowed).
- A car that completes the inbound sequence with `admit` = 0 still produces `entry_pulse`. The counter saturates it.
- At most one of `entry_pulse` / `exit_pulse` / `seq_error` is high in any cycle.

## Timing
- Reset values: all outputs 0, FSM IDLE, debounced levels 0, all counters 0, `admit` 0.
- Reset asserted mid-sequence returns the block to IDLE immediately, with no pulse.
- Latency from a raw beam edge, held stable, to the FSM state change is 2 + `DEBOUNCE_CYCLES` cycles.
- Pulses and `gate_open` are registered and appear in the cycle of the state change.
- Raw glitches shorter than `DEBOUNCE_CYCLES` cycles are invisible to the FSM.
- Timeout counter width is $clog2(`TIMEOUT_CYCLES`+1). Debounce counter width is $clog2(`DEBOUNCE_CYCLES`+1). Neither counter may wrap.

## Configuration
- `PARKING_GATE_CTRL_EN` defined: `full`/`admit` logic and `gate_open` behave as above.
- `PARKING_GATE_CTRL_EN` undefined:
  - `gate_open` is tied to 0;
  - `full` is ignored, with no `admit` register;
  - the port list is unchanged;
  - direction decoding and pulses are identical.

## Structure
- Shared package `parking_pkg` holds:
  - the FSM state encodings, as localparams in 3-bit binary;
  - the default `DEBOUNCE_CYCLES` / `TIMEOUT_CYCLES` constants.
- Sub-module `beam_debounce` contains the synchroniser and debounce counter. It is instantiated twice, once for A and once for B.
- The FSM, timeout counter and output registers live in the top.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `TIMEOUT_CYCLES`=50.
- Clean entry: raw A, AB, B, none, 10 cycles each, `full`=0. Expect:
  - exactly one `entry_pulse`, 6 cycles after the final clear;
  - `gate_open`=1 from IN_A to the pulse.
- Clean exit: raw B, AB, A, none. Expect one `exit_pulse`, no `entry_pulse`, `gate_open`=1 throughout.
- Full lot: `full`=1, then a complete inbound sequence. Expect `gate_open` to stay 0 and exactly one `entry_pulse`.
- Glitch and back-out: a 3-cycle A pulse produces no state change. Then A, AB, A, none produces no pulses and no `seq_error`.
- Error and timeout:
  - A and B rising in the same cycle from IDLE gives `seq_error` and WAIT_CLEAR.
  - Holding A for 60 cycles gives `seq_error` 50 cycles after IN_A.
  - Both cases recover to IDLE after both beams clear.
- Reset: deassert `rst_n` while in IN_AB. Expect all outputs 0 immediately, and the block accepts a new full entry afterwards.
